// File: rtl/rf_ldst_engine.sv
// Multi-line DMA engine moving register-file lines between SDRAM and the vector RF.
// Each RF line is transferred as BEATS SDRAM beats, lowest slice at the lowest address.
module rf_ldst_engine #(
    parameter int SDRAM_ADDR_W = 25,
    parameter int RF_ADDR_W    = 9,
    parameter int SDRAM_DATA_W = 128,
    parameter int RF_DATA_W    = 1408,
    parameter int LINE_CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ldst_start,
    input  logic                    ldst_dir,
    input  logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr,
    input  logic [RF_ADDR_W-1:0]    ldst_rf_addr,
    input  logic [LINE_CNT_W-1:0]   ldst_line_num,
    output logic                    ldst_busy,
    output logic                    ldst_done,
    output logic                    sdram_req,
    output logic                    sdram_we,
    output logic [SDRAM_ADDR_W-1:0] sdram_addr,
    output logic [SDRAM_DATA_W-1:0] sdram_wdata,
    input  logic                    sdram_ready,
    input  logic                    sdram_rvalid,
    input  logic [SDRAM_DATA_W-1:0] sdram_rdata,
    output logic                    rf_rd_en,
    output logic [RF_ADDR_W-1:0]    rf_rd_addr,
    input  logic [RF_DATA_W-1:0]    rf_rd_data,
    output logic                    rf_wr_en,
    output logic [RF_ADDR_W-1:0]    rf_wr_addr,
    output logic [RF_DATA_W-1:0]    rf_wr_data
);

    localparam int BEATS  = RF_DATA_W / SDRAM_DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((RF_DATA_W % SDRAM_DATA_W) != 0) begin : g_width_check
        $error("rf_ldst_engine: RF_DATA_W must be a multiple of SDRAM_DATA_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_WRITE,
        ST_RFRD,
        ST_RFWAIT,
        ST_REQ,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] sdram_addr_q;
    logic [RF_ADDR_W-1:0]    rf_addr_q;
    logic [LINE_CNT_W-1:0]   lines_left_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [RF_DATA_W-1:0]    line_buf_q;

    logic last_beat;
    logic last_line;

    assign last_beat = (beat_q == LAST_BEAT);
    assign last_line = (lines_left_q == LINE_CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        sdram_req = 1'b0;
        sdram_we  = 1'b0;
        rf_rd_en  = 1'b0;
        rf_wr_en  = 1'b0;
        ldst_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ldst_start) begin
                    if (ldst_line_num == '0) state_d = DONE;
                    else if (ldst_dir)       state_d = ST_RFRD;
                    else                     state_d = LD_REQ;
                end
            end
            LD_REQ: begin
                sdram_req = 1'b1;
                if (sdram_ready) state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (sdram_rvalid) state_d = last_beat ? LD_WRITE : LD_REQ;
            end
            LD_WRITE: begin
                rf_wr_en = 1'b1;
                state_d  = last_line ? DONE : LD_REQ;
            end
            ST_RFRD: begin
                rf_rd_en = 1'b1;
                state_d  = ST_RFWAIT;
            end
            ST_RFWAIT: state_d = ST_REQ;
            ST_REQ: begin
                sdram_req = 1'b1;
                sdram_we  = 1'b1;
                if (sdram_ready && last_beat) state_d = last_line ? DONE : ST_RFRD;
            end
            DONE: begin
                ldst_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Running addresses advance per accepted beat / per finished line; wrap is plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_addr_q <= '0;
            rf_addr_q    <= '0;
            lines_left_q <= '0;
            beat_q       <= '0;
            // NOTE: the line buffer is a plain register here, so it is cleared with everything else.
            line_buf_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            case (state_q)
                IDLE: begin
                    if (ldst_start) begin
                        sdram_addr_q <= ldst_sdram_addr;
                        rf_addr_q    <= ldst_rf_addr;
                        lines_left_q <= ldst_line_num;
                        beat_q       <= '0;
                    end
                end
                LD_REQ: begin
                    if (sdram_ready) sdram_addr_q <= sdram_addr_q + SDRAM_ADDR_W'(1);
                end
                LD_WAIT: begin
                    if (sdram_rvalid) begin
                        line_buf_q[beat_q*SDRAM_DATA_W +: SDRAM_DATA_W] <= sdram_rdata;
                        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                    end
                end
                LD_WRITE: begin
                    rf_addr_q    <= rf_addr_q + RF_ADDR_W'(1);
                    lines_left_q <= lines_left_q - LINE_CNT_W'(1);
                end
                ST_RFWAIT: line_buf_q <= rf_rd_data;
                ST_REQ: begin
                    if (sdram_ready) begin
                        sdram_addr_q <= sdram_addr_q + SDRAM_ADDR_W'(1);
                        if (last_beat) begin
                            beat_q       <= '0;
                            rf_addr_q    <= rf_addr_q + RF_ADDR_W'(1);
                            lines_left_q <= lines_left_q - LINE_CNT_W'(1);
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ldst_busy   = (state_q != IDLE) && (state_q != DONE);
    assign sdram_addr  = sdram_addr_q;
    assign sdram_wdata = line_buf_q[beat_q*SDRAM_DATA_W +: SDRAM_DATA_W];
    assign rf_rd_addr  = rf_addr_q;
    assign rf_wr_addr  = rf_addr_q;
    assign rf_wr_data  = line_buf_q;

endmodule

// File: tb/tb_rf_ldst_engine.sv
// Self-checking bench for rf_ldst_engine: SDRAM/RF responders, a transaction-level
// expectation model (queues of beats and line writes) and directed command scenarios.
module tb_rf_ldst_engine;

    localparam int SA    = 25;
    localparam int RA    = 9;
    localparam int SD    = 128;
    localparam int RD    = 1408;
    localparam int LC    = 8;
    localparam int BEATS = RD / SD;

    logic          clk;
    logic          rst_n;
    logic          ldst_start;
    logic          ldst_dir;
    logic [SA-1:0] ldst_sdram_addr;
    logic [RA-1:0] ldst_rf_addr;
    logic [LC-1:0] ldst_line_num;
    logic          ldst_busy;
    logic          ldst_done;
    logic          sdram_req;
    logic          sdram_we;
    logic [SA-1:0] sdram_addr;
    logic [SD-1:0] sdram_wdata;
    logic          sdram_ready;
    logic          sdram_rvalid;
    logic [SD-1:0] sdram_rdata;
    logic          rf_rd_en;
    logic [RA-1:0] rf_rd_addr;
    logic [RD-1:0] rf_rd_data;
    logic          rf_wr_en;
    logic [RA-1:0] rf_wr_addr;
    logic [RD-1:0] rf_wr_data;

    rf_ldst_engine #(
        .SDRAM_ADDR_W(SA), .RF_ADDR_W(RA), .SDRAM_DATA_W(SD),
        .RF_DATA_W(RD), .LINE_CNT_W(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ldst_start(ldst_start), .ldst_dir(ldst_dir),
        .ldst_sdram_addr(ldst_sdram_addr), .ldst_rf_addr(ldst_rf_addr),
        .ldst_line_num(ldst_line_num),
        .ldst_busy(ldst_busy), .ldst_done(ldst_done),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata), .sdram_ready(sdram_ready),
        .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [SD-1:0] act, input logic [SD-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expectation model: what the engine must do, as ordered transactions.
    typedef struct {
        logic          we;
        logic [SA-1:0] addr;
        logic [SD-1:0] wdata;
    } sd_exp_t;

    typedef struct {
        logic [RA-1:0] addr;
        logic [RD-1:0] data;
    } rfw_t;

    sd_exp_t       exp_sd[$];
    rfw_t          exp_rfwr[$];
    logic [RA-1:0] exp_rfrd[$];

    logic [RD-1:0] rf_mem [512];
    logic [SA-1:0] sd_data_base = '0;
    logic          sd_hi_en     = 1'b0;

    // SDRAM read content as a pure function of the beat address.
    function automatic logic [SD-1:0] sd_f(input logic [SA-1:0] a);
        logic [31:0]   w;
        logic [SA-1:0] d;
        w = 32'(a);
        d = a - sd_data_base;
        if (sd_hi_en) return {w ^ 32'h1111_1111, w ^ 32'h2222_2222, w ^ 32'h4444_4444, 32'(d)};
        return {96'h0, 32'(d)};
    endfunction

    task automatic gen_expect(input logic dir, input logic [SA-1:0] sd, input logic [RA-1:0] rf,
                              input int n);
        for (int l = 0; l < n; l++) begin
            logic [RA-1:0] ra;
            logic [RD-1:0] ln;
            ra = rf + RA'(l);
            ln = '0;
            if (dir) exp_rfrd.push_back(ra);
            for (int b = 0; b < BEATS; b++) begin
                logic [SA-1:0] a;
                a = sd + SA'(l * BEATS + b);
                if (dir) begin
                    exp_sd.push_back('{we: 1'b1, addr: a, wdata: rf_mem[ra][b*SD +: SD]});
                end else begin
                    exp_sd.push_back('{we: 1'b0, addr: a, wdata: '0});
                    ln[b*SD +: SD] = sd_f(a);
                end
            end
            if (!dir) exp_rfwr.push_back('{addr: ra, data: ln});
        end
    endtask

    // Responder state shared between the compare process and the drivers.
    logic          rd_pend = 1'b0;
    logic [SA-1:0] rd_pend_addr;
    logic          rf_pend = 1'b0;
    logic [RA-1:0] rf_pend_addr;
    logic [SA-1:0] stall_addr = '0;
    int            stall_left = 0;

    initial begin
        sdram_ready  = 1'b0;
        sdram_rvalid = 1'b0;
        sdram_rdata  = '0;
        rf_rd_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            sdram_rvalid = rd_pend;
            sdram_rdata  = rd_pend ? sd_f(rd_pend_addr) : {4{32'hBAD0_BAD0}};
            rd_pend      = 1'b0;
            rf_rd_data   = rf_pend ? rf_mem[rf_pend_addr] : {44{32'hDEAD_BEEF}};
            rf_pend      = 1'b0;
            sdram_ready  = 1'b1;
            if (sdram_req && stall_left > 0 && sdram_addr == stall_addr) begin
                sdram_ready = 1'b0;
                stall_left--;
            end
        end
    end

    // Observation counters.
    int            n_rd = 0, n_wr = 0, n_rfrd = 0, n_rfwr = 0;
    int            stall_seen = 0, done_cnt = 0, done_cyc = 0;
    logic [SA-1:0] last_rd_addr, last_wr_addr;
    logic [RA-1:0] rfwr_addrs[$];

    logic          prev_stall = 1'b0;
    logic          prev_we;
    logic [SA-1:0] prev_addr;
    logic [SD-1:0] prev_wdata;
    sd_exp_t       e;
    rfw_t          w;

    // Compare process: every DUT transaction is matched against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_req", sdram_req, 1'b1);
                check("hold_we_addr", {sdram_we, sdram_addr}, {prev_we, prev_addr});
                check("hold_wdata", sdram_wdata, prev_wdata);
            end
            prev_stall = sdram_req && !sdram_ready;
            if (prev_stall) begin
                prev_we    = sdram_we;
                prev_addr  = sdram_addr;
                prev_wdata = sdram_wdata;
                stall_seen++;
            end
            if (sdram_req && sdram_ready) begin
                check("sd_beat_expected", exp_sd.size() != 0, 1'b1);
                if (exp_sd.size() != 0) begin
                    e = exp_sd.pop_front();
                    check("sd_we", sdram_we, e.we);
                    check("sd_addr", sdram_addr, e.addr);
                    if (e.we) check("sd_wdata", sdram_wdata, e.wdata);
                end
                if (!sdram_we) begin
                    rd_pend      = 1'b1;
                    rd_pend_addr = sdram_addr;
                    last_rd_addr = sdram_addr;
                    n_rd++;
                end else begin
                    last_wr_addr = sdram_addr;
                    n_wr++;
                end
            end
            if (rf_rd_en) begin
                check("rf_rd_expected", exp_rfrd.size() != 0, 1'b1);
                if (exp_rfrd.size() != 0) check("rf_rd_addr", rf_rd_addr, exp_rfrd.pop_front());
                rf_pend      = 1'b1;
                rf_pend_addr = rf_rd_addr;
                n_rfrd++;
            end
            if (rf_wr_en) begin
                check("rf_wr_expected", exp_rfwr.size() != 0, 1'b1);
                if (exp_rfwr.size() != 0) begin
                    w = exp_rfwr.pop_front();
                    check("rf_wr_addr", rf_wr_addr, w.addr);
                    for (int b = 0; b < BEATS; b++)
                        check($sformatf("rf_wr_data[%0d]", b), rf_wr_data[b*SD +: SD], w.data[b*SD +: SD]);
                end
                rf_mem[rf_wr_addr] = rf_wr_data;
                rfwr_addrs.push_back(rf_wr_addr);
                n_rfwr++;
            end
            if (sdram_req || rf_rd_en || rf_wr_en) check("busy_when_active", ldst_busy, 1'b1);
            if (ldst_done) begin
                check("busy_low_at_done", ldst_busy, 1'b0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {ldst_busy, ldst_done, sdram_req, sdram_we, rf_rd_en, rf_wr_en}, '0);
        check({tag, "_sd_addr"}, sdram_addr, '0);
        check({tag, "_sd_wdata"}, sdram_wdata, '0);
        check({tag, "_rf_addrs"}, {rf_rd_addr, rf_wr_addr}, '0);
        check({tag, "_rf_wdata_any"}, |rf_wr_data, 1'b0);
    endtask

    task automatic issue(input logic dir, input logic [SA-1:0] sd, input logic [RA-1:0] rf,
                         input int n, output int st);
        @(posedge clk);
        #1;
        ldst_start      = 1'b1;
        ldst_dir        = dir;
        ldst_sdram_addr = sd;
        ldst_rf_addr    = rf;
        ldst_line_num   = LC'(n);
        st              = cyc;
        @(posedge clk);
        #1;
        ldst_start      = 1'b0;
        ldst_dir        = ~dir;
        ldst_sdram_addr = SA'($urandom);
        ldst_rf_addr    = RA'($urandom);
        ldst_line_num   = LC'($urandom);
        check("busy_after_start", ldst_busy, n != 0);
    endtask

    task automatic run_cmd(input logic dir, input logic [SA-1:0] sd, input logic [RA-1:0] rf,
                           input int n, input int exp_lat, input bit poke_busy);
        int st, d0;
        bit got;
        gen_expect(dir, sd, rf, n);
        d0 = done_cnt;
        issue(dir, sd, rf, n, st);
        if (poke_busy) begin
            repeat (3) @(posedge clk);
            #1;
            ldst_start      = 1'b1;
            ldst_dir        = ~dir;
            ldst_sdram_addr = 25'h7777;
            ldst_rf_addr    = 9'd100;
            ldst_line_num   = 8'd3;
            @(posedge clk);
            #1;
            ldst_start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) got = 1'b1;
        end
        check("done_seen", got, 1'b1);
        if (got) check("done_latency", done_cyc - st, exp_lat);
        repeat (2) @(negedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("model_drained", exp_sd.size() + exp_rfwr.size() + exp_rfrd.size(), 0);
    endtask

    initial begin
        int  act0, d0, st;
        bit  found;

        for (int i = 0; i < 512; i++)
            for (int k = 0; k < RD / 32; k++) rf_mem[i][k*32 +: 32] = $urandom;

        rst_n           = 1'b0;
        ldst_start      = 1'b0;
        ldst_dir        = 1'b0;
        ldst_sdram_addr = '0;
        ldst_rf_addr    = '0;
        ldst_line_num   = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Load one line; beat data equals beat index. A start while busy must be ignored.
        sd_data_base = 25'h100;
        sd_hi_en     = 1'b0;
        act0         = n_rd;
        run_cmd(1'b0, 25'h100, 9'd5, 1, 24, 1'b1);
        check("ld1_read_count", n_rd - act0, 11);
        check("ld1_last_read_addr", last_rd_addr, 25'h10A);
        for (int b = 0; b < BEATS; b++)
            check($sformatf("ld1_line5_slice%0d", b), rf_mem[5][b*SD +: SD], SD'(b));

        // Store two lines at full rate.
        sd_hi_en = 1'b1;
        act0     = n_wr;
        run_cmd(1'b1, 25'h2000, 9'd3, 2, 27, 1'b0);
        check("st2_write_count", n_wr - act0, 22);
        check("st2_last_write_addr", last_wr_addr, 25'h2015);

        // Backpressure: ready low for five cycles on beat 4.
        stall_addr = 25'h2004;
        stall_left = 5;
        act0       = stall_seen;
        run_cmd(1'b1, 25'h2000, 9'd7, 1, 19, 1'b0);
        check("bp_stall_cycles", stall_seen - act0, 5);

        // RF and SDRAM address wrap on a two-line load.
        sd_data_base = '0;
        rfwr_addrs.delete();
        run_cmd(1'b0, 25'h1FF_FFFA, 9'd511, 2, 47, 1'b0);
        check("wrap_rf_writes", rfwr_addrs.size(), 2);
        if (rfwr_addrs.size() == 2) begin
            check("wrap_first_line", rfwr_addrs[0], 9'd511);
            check("wrap_second_line", rfwr_addrs[1], 9'd0);
        end

        // Zero-line command: done the next cycle, no traffic.
        act0 = n_rd + n_wr + n_rfrd + n_rfwr;
        run_cmd(1'b0, 25'h55, 9'd9, 0, 1, 1'b0);
        check("noop_no_traffic", n_rd + n_wr + n_rfrd + n_rfwr - act0, 0);

        // Reset during beat 6 of a load aborts without a done pulse.
        gen_expect(1'b0, 25'h300, 9'd20, 1);
        d0 = done_cnt;
        issue(1'b0, 25'h300, 9'd20, 1, st);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (sdram_req && sdram_addr == 25'h306) found = 1'b1;
        end
        check("abort_reached_beat6", found, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_sd.delete();
        exp_rfwr.delete();
        exp_rfrd.delete();
        rd_pend = 1'b0;
        rf_pend = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // Fresh command after the abort.
        run_cmd(1'b0, 25'h400, 9'd21, 1, 24, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_ldst_engine.md
Name: rf_ldst_engine

Overview:
Parametrised multi-line DMA engine moving register-file lines between SDRAM and the vector register file, in either direction, selected per command. Each RF line of RF_DATA_W bits is split into BEATS = RF_DATA_W/SDRAM_DATA_W SDRAM beats. With the defaults 1408/128 = 11 beats. The engine sits between the NPU master/sequencer and the SDRAM controller and RF ports. It runs one command at a time and reports completion with a single-cycle done pulse.

Parameters:
SDRAM_ADDR_W, 25, SDRAM beat address width (one address = one SDRAM_DATA_W beat)
RF_ADDR_W, 9, RF line address width
SDRAM_DATA_W, 128, SDRAM beat width
RF_DATA_W, 1408, RF line width; must be an integer multiple of SDRAM_DATA_W (elaboration error otherwise)
LINE_CNT_W, 8, width of the line-count field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ldst_start  in  1  command strobe, sampled in IDLE only
ldst_dir  in  1  0 = load (SDRAM->RF), 1 = store (RF->SDRAM)
ldst_sdram_addr  in  SDRAM_ADDR_W  first SDRAM beat address
ldst_rf_addr  in  RF_ADDR_W  first RF line
ldst_line_num  in  LINE_CNT_W  number of lines; 0 = no-op
ldst_busy  out  1  high from the cycle after an accepted start until done
ldst_done  out  1  one-cycle completion pulse
sdram_req  out  1  beat request valid
sdram_we  out  1  1 = write beat, 0 = read beat
sdram_addr  out  SDRAM_ADDR_W  beat address
sdram_wdata  out  SDRAM_DATA_W  write beat data
sdram_ready  in  1  request accepted this cycle when high with sdram_req
sdram_rvalid  in  1  read data valid
sdram_rdata  in  SDRAM_DATA_W  read data
rf_rd_en  out  1  RF read strobe
rf_rd_addr  out  RF_ADDR_W  RF read line
rf_rd_data  in  RF_DATA_W  RF read data, valid exactly 1 cycle after rf_rd_en
rf_wr_en  out  1  RF write strobe
rf_wr_addr  out  RF_ADDR_W  RF write line
rf_wr_data  out  RF_DATA_W  RF write data

Behaviour:
- Reset: state IDLE. All outputs 0 and the line buffer cleared. A reset mid-command aborts it with no done pulse.
- Command capture: in IDLE, ldst_start=1 latches all command fields.
  - line_num=0: go to DONE.
  - dir=0: go to LD_REQ.
  - dir=1: go to ST_RFRD.
- ldst_start outside IDLE is ignored.
- Beat ordering: beat b maps to line bits [b*SDRAM_DATA_W +: SDRAM_DATA_W], with beat 0 at the lowest SDRAM address. sdram_addr = base + line_idx*BEATS + b.
- Address wrap: SDRAM and RF addresses wrap modulo 2^width silently.
- One SDRAM read is outstanding at a time. Read data returns in order.
- Load path:
  - LD_REQ: sdram_req=1, we=0. Stay until sdram_ready, then go to LD_WAIT.
  - LD_WAIT: on sdram_rvalid, store the beat in the buffer. If it is not the last beat, go to LD_REQ. If it is the last beat, go to LD_WRITE.
  - LD_WRITE: rf_wr_en=1 for one cycle with the full buffer. Then go to DONE if this was the last line, else LD_REQ.
- Store path:
  - ST_RFRD: rf_rd_en=1 for one cycle, then ST_RFWAIT.
  - ST_RFWAIT: capture rf_rd_data into the buffer, then ST_REQ.
  - ST_REQ: sdram_req=1, we=1, wdata = current beat. Each sdram_ready advances the beat. After the last beat, go to DONE if this was the last line, else ST_RFRD.
- sdram_req is held high and addr/wdata are held stable until ready. Back-to-back store beats are allowed (ready every cycle gives 1 beat/cycle).
- DONE: ldst_done=1 for one cycle, then IDLE.
- Busy: ldst_busy=1 in every state except IDLE and DONE.
- Stray sdram_rvalid outside LD_WAIT is ignored.
- Minimum load latency per line with ready=1 and rvalid next cycle: 2*BEATS+1 cycles.

Test Plan:
- Load 1 line: sdram_addr=0x100, rf_addr=5. The model returns data = beat index, with ready=1 and rvalid one cycle later. -> 11 read reqs at addresses 0x100..0x10A; one rf_wr to line 5 with slice b = b; done pulses once, 24 cycles after start.
- Store 2 lines, rf_addr=3, sdram_addr=0x2000, ready=1. -> rf_rd of lines 3 then 4; 22 write beats at 0x2000..0x2015 carrying the matching slices in order; single done pulse.
- Backpressure: store 1 line with ready low for 5 cycles on beat 4. -> addr=0x2004 and wdata held stable throughout; no beat is skipped or duplicated.
- Wrap: load 2 lines with rf_addr=511. -> writes go to lines 511 then 0.
- line_num=0 -> done in the cycle after start, with no SDRAM or RF activity. A start pulsed while busy is ignored.
- Reset asserted during beat 6 of a load. -> all outputs 0 immediately, no done. A fresh command after reset completes normally.
